// File: rtl/correlation_pkg.sv
// Shared definitions for the correlator datapath.
//
// Contents:
//   CORR_DATA_W  - sample width in bits.
//   CORR_TAPS    - correlator window length.
//   CORR_OUT_W   - width of the correlator result.
//   corr_state_e - window-feeder FSM encoding (FILL while the window is
//                  still filling, RUN once it has filled and windows are
//                  emitted at the stride rate).
package correlation_pkg;

  localparam int CORR_DATA_W = 4;
  localparam int CORR_TAPS   = 10;
  localparam int CORR_OUT_W  = 12;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } corr_state_e;

endpackage : correlation_pkg

// File: rtl/correlation_tap_shift.sv
// TAPS x DATA_W shift register that holds the correlator window.
//
// Ports:
//   clock    - rising-edge clock.
//   reset    - asynchronous active-low reset; clears every tap.
//   clear    - synchronous clear of every tap; has priority over shift_en.
//   shift_en - shift the window by one sample this cycle.
//   sample   - sample that enters at the newest end of the window.
//   taps     - window contents; taps[0] is the oldest sample and
//              taps[TAPS-1] is the newest.
module correlation_tap_shift
  import correlation_pkg::*;
#(
  parameter int DATA_W = CORR_DATA_W,
  parameter int TAPS   = CORR_TAPS
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         shift_en,
  input  logic [DATA_W-1:0]            sample,
  output logic [TAPS-1:0][DATA_W-1:0]  taps
);

  // NOTE: the taps sit in flops rather than a RAM, so they take the
  // asynchronous reset; the window must read as all zeros straight out of
  // reset, not just after TAPS samples have pushed the old contents out.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      taps <= '0;
    end else if (clear) begin
      taps <= '0;
    end else if (shift_en) begin
      // NOTE: non-blocking assignment, so every tap reads its neighbour's
      // pre-edge value and the whole window moves by exactly one place.
      taps <= {sample, taps[TAPS-1:1]};
    end
  end

endmodule : correlation_tap_shift

// File: rtl/correlation_window_feeder.sv
// Upstream stage of the 10-tap correlator. Turns a serial stream of samples
// (valid/ready) into a sliding window of the last TAPS samples, presented in
// parallel with a window-valid handshake. A window is only offered once the
// window has filled, then once every STRIDE new samples. Taps never change
// while an offered window is waiting to be taken.
//
// Ports:
//   clock      - rising-edge clock.
//   reset      - asynchronous active-low reset.
//   flush      - synchronous clear of window, counters and win_valid; wins
//                over a sample accepted in the same cycle.
//   in_sample  - serial input sample.
//   in_valid   - in_sample is valid.
//   in_ready   - a sample can be accepted this cycle.
//   x_0..x_9   - window taps, x_0 oldest and x_9 newest.
//   win_valid  - x_0..x_9 hold a complete window for the correlator.
//   win_ready  - correlator takes the window this cycle.
//   fill_count - number of valid samples in the window, saturates at TAPS.
module correlation_window_feeder
  import correlation_pkg::*;
#(
  parameter int DATA_W = CORR_DATA_W,
  parameter int TAPS   = CORR_TAPS,
  parameter int STRIDE = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [DATA_W-1:0]           in_sample,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [DATA_W-1:0]           x_0,
  output logic [DATA_W-1:0]           x_1,
  output logic [DATA_W-1:0]           x_2,
  output logic [DATA_W-1:0]           x_3,
  output logic [DATA_W-1:0]           x_4,
  output logic [DATA_W-1:0]           x_5,
  output logic [DATA_W-1:0]           x_6,
  output logic [DATA_W-1:0]           x_7,
  output logic [DATA_W-1:0]           x_8,
  output logic [DATA_W-1:0]           x_9,
  output logic                        win_valid,
  input  logic                        win_ready,
  output logic [$clog2(TAPS+1)-1:0]   fill_count
);

  localparam int CNT_W = $clog2(TAPS + 1);

  // The port list is hard-wired to ten taps.
  if (TAPS != 10) begin : g_bad_taps
    $error("correlation_window_feeder: TAPS must be 10");
  end
  if (STRIDE < 1 || STRIDE > TAPS) begin : g_bad_stride
    $error("correlation_window_feeder: STRIDE must be in 1..TAPS");
  end

  corr_state_e             state_q, state_d;
  logic [CNT_W-1:0]        fill_q, fill_d;
  logic [CNT_W-1:0]        stride_q, stride_d;
  logic                    win_valid_q, win_valid_d;
  logic                    accept;
  logic [TAPS-1:0][DATA_W-1:0] taps;

  // Backpressure only while an offered window is still untaken, so the taps
  // cannot move underneath the correlator.
  assign in_ready = ~(win_valid_q & ~win_ready);
  assign accept   = in_valid & in_ready;

  correlation_tap_shift #(
    .DATA_W (DATA_W),
    .TAPS   (TAPS)
  ) u_tap_shift (
    .clock    (clock),
    .reset    (reset),
    .clear    (flush),
    .shift_en (accept & ~flush),
    .sample   (in_sample),
    .taps     (taps)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= FILL;
      fill_q      <= '0;
      stride_q    <= '0;
      win_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      stride_q    <= stride_d;
      win_valid_q <= win_valid_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default before any branch, so
    // no path can leave one unassigned and infer a latch.
    state_d     = state_q;
    fill_d      = fill_q;
    stride_d    = stride_q;
    win_valid_d = win_valid_q;

    // A taken window drops win_valid unless the same edge completes the
    // next window; the assignments below then set it again.
    if (win_valid_q && win_ready) begin
      win_valid_d = 1'b0;
    end

    if (flush) begin
      state_d     = FILL;
      fill_d      = '0;
      stride_d    = '0;
      win_valid_d = 1'b0;
    end else if (accept) begin
      unique case (state_q)
        FILL: begin
          fill_d = fill_q + CNT_W'(1);
          if (fill_q == CNT_W'(TAPS - 1)) begin
            state_d     = RUN;
            stride_d    = '0;
            win_valid_d = 1'b1;
          end
        end
        RUN: begin
          // fill_count holds at TAPS; only the stride counter advances.
          if (stride_q == CNT_W'(STRIDE - 1)) begin
            stride_d    = '0;
            win_valid_d = 1'b1;
          end else begin
            stride_d = stride_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = FILL;
        end
      endcase
    end
  end

  assign win_valid  = win_valid_q;
  assign fill_count = fill_q;

  assign x_0 = taps[0];
  assign x_1 = taps[1];
  assign x_2 = taps[2];
  assign x_3 = taps[3];
  assign x_4 = taps[4];
  assign x_5 = taps[5];
  assign x_6 = taps[6];
  assign x_7 = taps[7];
  assign x_8 = taps[8];
  assign x_9 = taps[9];

endmodule : correlation_window_feeder
